frame_rx_ctrl: RTL and testbench

Receive-side frame controller that pairs with the two-byte frame transmit control. It consumes bytes from the UART receiver (`rx_rdy`/`rx_data`) and assembles two consecutive bytes, high byte first, into a 16-bit command word. It presents the word to the command processor with a sticky `cmd_rdy` flag. It also detects broken frames with an inter-byte timeout and reports unconsumed commands that were overwritten.

---
 rtl/frame_pkg.sv | 17 +
 rtl/frm_tmo_cnt.sv | 30 +++
 rtl/frame_rx_ctrl.sv | 92 +++++++++
 tb/tb_frame_rx_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Types and widths shared by the two-byte frame transmit and receive controllers.
package frame_pkg;

    localparam int CMD_W  = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [0:0] {
        HI_WAIT = 1'b0,
        LO_WAIT = 1'b1
    } frx_state_t;

    function automatic logic [CMD_W-1:0] make_cmd(input logic [BYTE_W-1:0] hi,
                                                  input logic [BYTE_W-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/frm_tmo_cnt.sv
// Inter-byte timeout counter; tmo flags the terminal count TIMEOUT-1 (never when TIMEOUT is 0).
module frm_tmo_cnt #(
    parameter int TIMEOUT = 50000,
    parameter int TMO_W   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tmo
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] cnt;

    // Count idle cycles while a half frame is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

    assign tmo = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/frame_rx_ctrl.sv
// Receive frame controller: pairs UART bytes (high first) into 16-bit commands,
// with inter-byte timeout and overwrite detection.
module frame_rx_ctrl
    import frame_pkg::*;
#(
    parameter int TIMEOUT = 50000,
    parameter int TMO_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              clr_rx_rdy,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_rdy,
    input  logic              clr_cmd_rdy,
    output logic              frm_err,
    output logic              ovr
);

    frx_state_t        state;
    logic [BYTE_W-1:0] hi_q;
    logic              tmo;
    logic              cnt_clr;
    logic              cnt_en;

    // Counter control: restart on a high byte, count idle cycles in LO_WAIT.
    always_comb begin
        cnt_clr    = rx_rdy && (state == HI_WAIT);
        cnt_en     = !rx_rdy && (state == LO_WAIT);
        clr_rx_rdy = rx_rdy && !rst;
    end

    frm_tmo_cnt #(
        .TIMEOUT(TIMEOUT),
        .TMO_W  (TMO_W)
    ) u_tmo (
        .clk(clk),
        .rst(rst),
        .clr(cnt_clr),
        .en (cnt_en),
        .tmo(tmo)
    );

    // Frame FSM and output flags; later assignments give completion priority over acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= HI_WAIT;
            hi_q    <= '0;
            cmd     <= '0;
            cmd_rdy <= 1'b0;
            ovr     <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            frm_err <= 1'b0;
            if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
                ovr     <= 1'b0;
            end
            case (state)
                HI_WAIT: begin
                    if (rx_rdy) begin
                        hi_q  <= rx_data;
                        state <= LO_WAIT;
                        // A new frame overwrites an unconsumed command.
                        if (cmd_rdy) begin
                            cmd_rdy <= 1'b0;
                            if (!clr_cmd_rdy) begin
                                ovr <= 1'b1;
                            end
                        end
                    end
                end
                LO_WAIT: begin
                    if (rx_rdy) begin
                        cmd     <= make_cmd(hi_q, rx_data);
                        cmd_rdy <= 1'b1;
                        state   <= HI_WAIT;
                    end else if (tmo) begin
                        frm_err <= 1'b1;
                        hi_q    <= '0;
                        state   <= HI_WAIT;
                    end
                end
                default: begin
                    state <= HI_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_rx_ctrl.sv
// Self-checking bench for frame_rx_ctrl: directed frames plus randomized byte streams
// compared every cycle against a timestamp-based frame model.
module tb_frame_rx_ctrl;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_cmd_rdy = 1'b0;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        frm_err;
    logic        ovr;

    int vectors = 0;
    int errors  = 0;
    bit model_live = 1'b0;

    // Model state: pending high byte and the cycle it was accepted in.
    logic [15:0] m_cmd;
    logic        m_rdy, m_ovr, m_err, m_pend;
    logic [7:0]  m_hi;
    int          m_thi;
    int          cyc = 0;

    frame_rx_ctrl #(.TIMEOUT(TMO), .TMO_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .clr_rx_rdy (clr_rx_rdy),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .frm_err    (frm_err),
        .ovr        (ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model updated at each rising edge from the sampled inputs.
    initial begin
        bit done, start;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_cmd = 16'h0000; m_rdy = 1'b0; m_ovr = 1'b0; m_err = 1'b0;
                m_pend = 1'b0; m_hi = 8'h00; m_thi = 0;
                model_live = 1'b1;
            end else if (model_live) begin
                done = 1'b0; start = 1'b0; m_err = 1'b0;
                if (m_pend && rx_rdy) begin
                    m_cmd = {m_hi, rx_data}; done = 1'b1; m_pend = 1'b0;
                end else if (m_pend && (cyc - m_thi == TMO)) begin
                    m_err = 1'b1; m_pend = 1'b0;
                end else if (!m_pend && rx_rdy) begin
                    start = 1'b1; m_pend = 1'b1; m_hi = rx_data; m_thi = cyc;
                end
                if (clr_cmd_rdy) m_ovr = 1'b0;
                if (start && m_rdy && !clr_cmd_rdy) m_ovr = 1'b1;
                if (clr_cmd_rdy || start) m_rdy = 1'b0;
                if (done) m_rdy = 1'b1;
            end
        end
    end

    // Per-cycle comparison, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (model_live) begin
                chk("clr_rx_rdy", {15'd0, clr_rx_rdy}, {15'd0, rx_rdy & ~rst});
                chk("cmd",        cmd,                 m_cmd);
                chk("cmd_rdy",    {15'd0, cmd_rdy},    {15'd0, m_rdy});
                chk("ovr",        {15'd0, ovr},        {15'd0, m_ovr});
                chk("frm_err",    {15'd0, frm_err},    {15'd0, m_err});
            end
        end
    end

    task automatic step(input logic r, input logic [7:0] d, input logic c, input logic rs);
        @(negedge clk);
        rx_rdy = r; rx_data = d; clr_cmd_rdy = c; rst = rs;
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        int g;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle(); #2;
        chk("rst_cmd", cmd, 16'h0000);
        chk("rst_cmd_rdy", {15'd0, cmd_rdy}, 16'h0000);
        chk("rst_ovr", {15'd0, ovr}, 16'h0000);
        chk("rst_frm_err", {15'd0, frm_err}, 16'h0000);

        // Normal frame with a 3-cycle gap.
        send(8'hA5); #2; chk("clr_hi", {15'd0, clr_rx_rdy}, 16'h0001);
        idle(); idle(); idle();
        send(8'h3C); #2; chk("clr_lo", {15'd0, clr_rx_rdy}, 16'h0001);
        idle(); #2;
        chk("cmd_a53c", cmd, 16'hA53C);
        chk("rdy_a53c", {15'd0, cmd_rdy}, 16'h0001);
        chk("ovr_a53c", {15'd0, ovr}, 16'h0000);
        chk("idle_clr", {15'd0, clr_rx_rdy}, 16'h0000);

        // Acknowledge, then a second frame.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle(); #2;
        chk("ack_rdy", {15'd0, cmd_rdy}, 16'h0000);
        chk("ack_cmd", cmd, 16'hA53C);
        send(8'h12); send(8'h34); idle(); #2;
        chk("cmd_1234", cmd, 16'h1234);

        // Timeout: frm_err exactly at t+9.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        send(8'h55);
        for (int k = 1; k <= 10; k++) begin
            idle(); #2;
            chk($sformatf("tmo_err_t%0d", k), {15'd0, frm_err}, (k == 9) ? 16'h0001 : 16'h0000);
        end
        send(8'h01); send(8'h02); idle(); #2;
        chk("cmd_0102", cmd, 16'h0102);

        // Low byte lands in the terminal-count cycle.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        send(8'h66);
        repeat (7) idle();
        send(8'h77);
        for (int k = 0; k < 4; k++) begin
            idle(); #2;
            chk("race_err", {15'd0, frm_err}, 16'h0000);
        end
        chk("cmd_6677", cmd, 16'h6677);
        chk("rdy_6677", {15'd0, cmd_rdy}, 16'h0001);

        // Overrun, then completion while acknowledging.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        send(8'hDE); send(8'hAD); idle(); #2;
        chk("cmd_dead", cmd, 16'hDEAD);
        send(8'hBE);
        step(1'b1, 8'hEF, 1'b1, 1'b0); #2;
        chk("ovr_set", {15'd0, ovr}, 16'h0001);
        chk("ovr_rdy", {15'd0, cmd_rdy}, 16'h0000);
        idle(); #2;
        chk("cmd_beef", cmd, 16'hBEEF);
        chk("rdy_beef", {15'd0, cmd_rdy}, 16'h0001);

        // Mid-frame reset.
        send(8'h99);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle(); #2;
        chk("mrst_cmd", cmd, 16'h0000);
        chk("mrst_rdy", {15'd0, cmd_rdy}, 16'h0000);
        chk("mrst_ovr", {15'd0, ovr}, 16'h0000);
        chk("mrst_err", {15'd0, frm_err}, 16'h0000);
        send(8'hAB); send(8'hCD); idle(); #2;
        chk("cmd_abcd", cmd, 16'hABCD);

        // Randomized byte stream with gaps that straddle the timeout.
        repeat (300) begin
            g = $urandom_range(0, 11);
            repeat (g) step(1'b0, 8'($urandom), ($urandom % 8 == 0), 1'b0);
            step(1'b1, 8'($urandom), ($urandom % 5 == 0), ($urandom % 60 == 0));
        end
        repeat (12) idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
